mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port synchronous data memory between three requesters: the flash loader, the core's load/store (data) port and the instruction-fetch port.
- Owns the memory's addr/wren/wr_data/rd_data pins. The memory's own flash_en is tied low; flashing is routed through this block.
- Sequences flash-mode lockout and drain.
- Steers 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- WIDTH, 32, data/address width of every requester and memory port.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flash_en  in  1  flash loader active; one write per cycle while high
- flash_addr  in  WIDTH  flash write byte address
- flash_data  in  WIDTH  flash write data
- d_req  in  1  data-port request
- d_wren  in  1  data-port write (1) / read (0)
- d_addr  in  WIDTH  data-port byte address
- d_wr_data  in  WIDTH  data-port write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read result valid
- d_rd_data  out  WIDTH  data read result
- i_req  in  1  fetch request (read only)
- i_addr  in  WIDTH  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch result valid
- i_rd_data  out  WIDTH  fetch result
- mem_addr  out  WIDTH  to memory addr
- mem_wren  out  1  to memory wren
- mem_wr_data  out  WIDTH  to memory wr_data
- mem_rd_data  in  WIDTH  from memory rd_data; valid the cycle after a read is issued

Behaviour:
- FSM states:
  - RUN to FLASH when flash_en=1.
  - FLASH to DRAIN when flash_en=0.
  - DRAIN to RUN after exactly 1 cycle.
  - DRAIN to FLASH if flash_en reasserts during DRAIN.
- Reset: state=RUN, rr=0 (data wins the first tie), pending read cleared.
- Grants during reset: d_gnt, i_gnt, d_rvalid, i_rvalid and mem_wren are all 0 while rst=1. A read issued the cycle rst rises produces no rvalid.
- FLASH state, or flash_en=1 in any state:
  - mem_addr=flash_addr, mem_wren=1, mem_wr_data=flash_data.
  - d_gnt=i_gnt=0.
  - flash_en preempts immediately in the same cycle; an outstanding read's rvalid still fires next cycle.
- DRAIN: no grants, mem_wren=0. This guarantees the last flash write completes before CPU access.
- RUN arbitration (combinational, same cycle):
  - Only d_req: grant data.
  - Only i_req: grant fetch.
  - Both requesting: grant data if rr=0, else fetch. rr updates on every grant (1 after a data grant, 0 after a fetch grant).
  - At most one gnt per cycle.
- Granted access: mem_addr/mem_wren/mem_wr_data come from the winner; fetch forces mem_wren=0. With no grant, mem_wren=0 and mem_addr=0.
- Handshake:
  - Requester holds req/addr/wren/wr_data stable until gnt=1. A transfer completes on the cycle req and gnt are both 1.
  - Writes produce no rvalid.
  - A granted read registers its owner. Exactly one cycle later, the owner's rvalid pulses for 1 cycle with rd_data=mem_rd_data.
  - The non-owner's rd_data is 0 and its rvalid is 0.
- Back-to-back: a new grant may be issued in the cycle a previous read's rvalid is asserted, giving full throughput of one access per cycle.
- Addresses pass through unmodified at full width. Word selection and the outport at 0xFFFC stay in memory.

Optional Feature:
- MEM_ARB_PERF_CNT_EN defined: adds outputs d_stall_cnt and i_stall_cnt (32 bits each).
  - A counter increments each cycle its req=1 and gnt=0.
  - Counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: these ports and registers do not exist.

Test Plan:
- Single read: d_req=1, d_wren=0, d_addr=0x10 (mem word 4 = 0xDEADBEEF) → d_gnt=1 that cycle; d_rvalid=1 with d_rd_data=0xDEADBEEF next cycle; i_rvalid=0.
- Contention: d_req and i_req held high 4 cycles after reset → grants alternate D, I, D, I; each rvalid goes to the correct port one cycle after its grant.
- Flash: flash_en=1 for 3 cycles writing 0x0, 0x4, 0x8 while i_req=1 → i_gnt=0 during those 3 cycles plus 1 DRAIN cycle; i_gnt=1 on the 5th cycle; the fetch of 0x4 returns the flashed value.
- Preempt: read granted to fetch in cycle N, flash_en rises in N+1 → i_rvalid still asserts in N+1 with correct data; mem_wren=1 with flash signals.
- Reset mid-read: d read granted, rst=1 next cycle → d_rvalid=0; after rst falls with both requesting, data granted first.
- Perf (MEM_ARB_PERF_CNT_EN): i_req held during 3-cycle flash plus 1 DRAIN → i_stall_cnt=4.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port data memory arbiter for flash loader, data port and fetch port
//
// Purpose:
//   Shares one single-port synchronous memory (1-cycle read latency) between the
//   flash loader, the core data (load/store) port and the instruction-fetch port.
//   Flash always preempts; after flashing ends one drain cycle is inserted before
//   CPU traffic resumes. Data and fetch ties are resolved round-robin.
//
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   flash_en, flash_addr, flash_data          flash loader write stream
//   d_req, d_wren, d_addr, d_wr_data          data-port request
//   d_gnt, d_rvalid, d_rd_data                data-port grant / read response
//   i_req, i_addr                             fetch request (read only)
//   i_gnt, i_rvalid, i_rd_data                fetch grant / read response
//   mem_addr, mem_wren, mem_wr_data           memory command pins
//   mem_rd_data                               memory read data (cycle after the read)
//   d_stall_cnt, i_stall_cnt                  stall counters, only with MEM_ARB_PERF_CNT_EN
//
// Build option:
//   MEM_ARB_PERF_CNT_EN  adds saturating 32-bit per-requester stall counters.

module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flash_en,
    input  logic [WIDTH-1:0] flash_addr,
    input  logic [WIDTH-1:0] flash_data,
    input  logic             d_req,
    input  logic             d_wren,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wr_data,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rd_data,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rd_data,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wren,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd_data
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      d_stall_cnt,
    output logic [31:0]      i_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLASH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // state holds the phase of the previous cycle; phase is the live phase of
    // this cycle. Flash must preempt in the very cycle flash_en rises, and the
    // cycle flash_en falls is itself the single drain cycle, so both edges of
    // flash_en act combinationally. A registered DRAIN therefore means the
    // drain has already happened and CPU access resumes now.
    state_t state;
    state_t phase;

    logic   rr;        // 0: data wins a tie, 1: fetch wins a tie
    logic   rd_d_q;    // data port owns the read issued last cycle
    logic   rd_i_q;    // fetch port owns the read issued last cycle
    logic   pick_d;
    logic   pick_i;

    always_comb begin
        phase = RUN;
        case (state)
            RUN:     phase = flash_en ? FLASH : RUN;
            FLASH:   phase = flash_en ? FLASH : DRAIN;
            DRAIN:   phase = flash_en ? FLASH : RUN;
            default: phase = RUN;
        endcase
    end

    always_comb begin
        pick_d = 1'b0;
        pick_i = 1'b0;
        if (!rst && phase == RUN) begin
            pick_d = d_req && (!i_req || !rr);
            pick_i = i_req && !pick_d;
        end
    end

    assign d_gnt = pick_d;
    assign i_gnt = pick_i;

    always_comb begin
        mem_addr    = '0;
        mem_wren    = 1'b0;
        mem_wr_data = '0;
        if (!rst && phase == FLASH) begin
            mem_addr    = flash_addr;
            mem_wren    = 1'b1;
            mem_wr_data = flash_data;
        end else if (pick_d) begin
            mem_addr    = d_addr;
            mem_wren    = d_wren;
            mem_wr_data = d_wr_data;
        end else if (pick_i) begin
            mem_addr    = i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            rr     <= 1'b0;
            rd_d_q <= 1'b0;
            rd_i_q <= 1'b0;
        end else begin
            state  <= phase;
            if (pick_d) begin
                rr <= 1'b1;
            end else if (pick_i) begin
                rr <= 1'b0;
            end
            rd_d_q <= pick_d && !d_wren;
            rd_i_q <= pick_i;
        end
    end

    // A read granted just before reset must not surface while reset is high.
    assign d_rvalid  = rd_d_q && !rst;
    assign i_rvalid  = rd_i_q && !rst;
    assign d_rd_data = d_rvalid ? mem_rd_data : '0;
    assign i_rd_data = i_rvalid ? mem_rd_data : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            d_stall_cnt <= '0;
            i_stall_cnt <= '0;
        end else begin
            if (d_req && !pick_d && d_stall_cnt != 32'hFFFF_FFFF) begin
                d_stall_cnt <= d_stall_cnt + 32'd1;
            end
            if (i_req && !pick_i && i_stall_cnt != 32'hFFFF_FFFF) begin
                i_stall_cnt <= i_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        flash_en;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        d_req;
    logic        d_wren;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rd_data;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rd_data;
    logic [31:0] mem_addr;
    logic        mem_wren;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] d_stall_cnt;
    logic [31:0] i_stall_cnt;
`endif

    int checks;
    int errors;

    logic [31:0] mem [0:63];

    mem_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flash_en   (flash_en),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .d_req      (d_req),
        .d_wren     (d_wren),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rd_data  (d_rd_data),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rd_data  (i_rd_data),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .d_stall_cnt(d_stall_cnt),
        .i_stall_cnt(i_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: 64 words, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_wren) begin
            mem[mem_addr[7:2]] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        flash_en = 1'b0; flash_addr = '0; flash_data = '0;
        d_req = 1'b0; d_wren = 1'b0; d_addr = '0; d_wr_data = '0;
        i_req = 1'b0; i_addr = '0;
        for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 | k;
        mem[4] = 32'hDEAD_BEEF;

        // Reset with every requester active: nothing granted, nothing written.
        next_cycle();
        d_req = 1'b1; d_addr = 32'h10; i_req = 1'b1;
        flash_en = 1'b1; flash_addr = 32'h3C; flash_data = 32'h0000_0BAD;
        @(negedge clk);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_d_rvalid", d_rvalid, 0);

        // Single data read of word 4.
        next_cycle();
        rst = 1'b0; flash_en = 1'b0; i_req = 1'b0;
        d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h10;
        @(negedge clk);
        chk("rd_d_gnt", d_gnt, 1);
        chk("rd_i_gnt", i_gnt, 0);
        chk("rd_addr", mem_addr, 32'h10);
        chk("rd_wren", mem_wren, 0);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("rd_d_rvalid", d_rvalid, 1);
        chk("rd_d_data", d_rd_data, 32'hDEAD_BEEF);
        chk("rd_i_rvalid", i_rvalid, 0);
        chk("rd_i_data", i_rd_data, 0);
        next_cycle();
        @(negedge clk);
        chk("idle_d_rvalid", d_rvalid, 0);
        chk("idle_addr", mem_addr, 0);

        // Contention straight after reset: D, I, D, I.
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        d_req = 1'b1; d_addr = 32'h20; i_req = 1'b1; i_addr = 32'h24;
        @(negedge clk);
        chk("c1_d_gnt", d_gnt, 1);
        chk("c1_i_gnt", i_gnt, 0);
        chk("c1_addr", mem_addr, 32'h20);
        next_cycle();
        @(negedge clk);
        chk("c2_d_gnt", d_gnt, 0);
        chk("c2_i_gnt", i_gnt, 1);
        chk("c2_addr", mem_addr, 32'h24);
        chk("c2_d_rvalid", d_rvalid, 1);
        chk("c2_d_data", d_rd_data, 32'hA000_0008);
        chk("c2_i_rvalid", i_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("c3_d_gnt", d_gnt, 1);
        chk("c3_i_gnt", i_gnt, 0);
        chk("c3_i_rvalid", i_rvalid, 1);
        chk("c3_i_data", i_rd_data, 32'hA000_0009);
        chk("c3_d_rvalid", d_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("c4_i_gnt", i_gnt, 1);
        chk("c4_d_gnt", d_gnt, 0);
        chk("c4_d_rvalid", d_rvalid, 1);
        chk("c4_d_data", d_rd_data, 32'hA000_0008);
        next_cycle();
        d_req = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("c5_i_rvalid", i_rvalid, 1);
        chk("c5_i_data", i_rd_data, 32'hA000_0009);
        chk("c5_d_rvalid", d_rvalid, 0);

        // Data write, then back-to-back readback.
        next_cycle();
        d_req = 1'b1; d_wren = 1'b1; d_addr = 32'h30; d_wr_data = 32'h1234_5678;
        @(negedge clk);
        chk("wr_d_gnt", d_gnt, 1);
        chk("wr_wren", mem_wren, 1);
        chk("wr_data", mem_wr_data, 32'h1234_5678);
        next_cycle();
        d_wren = 1'b0;
        @(negedge clk);
        chk("wr_no_rvalid", d_rvalid, 0);
        chk("rb_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("rb_d_rvalid", d_rvalid, 1);
        chk("rb_d_data", d_rd_data, 32'h1234_5678);

        // Flash three words with fetch waiting; one drain cycle follows.
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        flash_en = 1'b1; flash_addr = 32'h0; flash_data = 32'hF1A5_0000;
        i_req = 1'b1; i_addr = 32'h4;
        @(negedge clk);
        chk("f1_i_gnt", i_gnt, 0);
        chk("f1_wren", mem_wren, 1);
        chk("f1_addr", mem_addr, 32'h0);
        chk("f1_data", mem_wr_data, 32'hF1A5_0000);
        next_cycle();
        flash_addr = 32'h4; flash_data = 32'hF1A5_0004;
        @(negedge clk);
        chk("f2_i_gnt", i_gnt, 0);
        chk("f2_addr", mem_addr, 32'h4);
        chk("f2_data", mem_wr_data, 32'hF1A5_0004);
        next_cycle();
        flash_addr = 32'h8; flash_data = 32'hF1A5_0008;
        @(negedge clk);
        chk("f3_i_gnt", i_gnt, 0);
        chk("f3_wren", mem_wren, 1);
        next_cycle();
        flash_en = 1'b0;
        @(negedge clk);
        chk("drain_i_gnt", i_gnt, 0);
        chk("drain_wren", mem_wren, 0);
        next_cycle();
        @(negedge clk);
        chk("f5_i_gnt", i_gnt, 1);
        chk("f5_addr", mem_addr, 32'h4);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_i_stall", i_stall_cnt, 4);
        chk("perf_d_stall", d_stall_cnt, 0);
`endif
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        chk("f6_i_rvalid", i_rvalid, 1);
        chk("f6_i_data", i_rd_data, 32'hF1A5_0004);

        // Flash preempts the cycle after a fetch read; its rvalid still fires.
        next_cycle();
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        chk("pn_i_gnt", i_gnt, 1);
        next_cycle();
        i_req = 1'b0;
        flash_en = 1'b1; flash_addr = 32'h3C; flash_data = 32'h55AA_55AA;
        @(negedge clk);
        chk("pn1_i_rvalid", i_rvalid, 1);
        chk("pn1_i_data", i_rd_data, 32'hF1A5_0008);
        chk("pn1_wren", mem_wren, 1);
        chk("pn1_addr", mem_addr, 32'h3C);
        chk("pn1_data", mem_wr_data, 32'h55AA_55AA);
        next_cycle();
        flash_en = 1'b0;
        d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h3C;
        @(negedge clk);
        chk("pn2_d_gnt", d_gnt, 0);
        chk("pn2_wren", mem_wren, 0);
        chk("pn2_i_rvalid", i_rvalid, 0);
        next_cycle();
        @(negedge clk);
        chk("pn3_d_gnt", d_gnt, 1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("pn4_d_rvalid", d_rvalid, 1);
        chk("pn4_d_data", d_rd_data, 32'h55AA_55AA);

        // Reset the cycle after a granted data read.
        next_cycle();
        d_req = 1'b1; d_addr = 32'h10;
        @(negedge clk);
        chk("rm_d_gnt", d_gnt, 1);
        next_cycle();
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rm_d_rvalid", d_rvalid, 0);
        chk("rm_d_data", d_rd_data, 0);
        next_cycle();
        rst = 1'b0;
        d_req = 1'b1; d_addr = 32'h10; i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        chk("rm2_d_gnt", d_gnt, 1);
        chk("rm2_i_gnt", i_gnt, 0);
        chk("rm2_d_rvalid", d_rvalid, 0);
        next_cycle();
        d_req = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("rm3_d_rvalid", d_rvalid, 1);
        chk("rm3_d_data", d_rd_data, 32'hDEAD_BEEF);
        chk("rm3_i_rvalid", i_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
